food_placer: RTL and testbench

- Consumes the free-running pseudo-random point stream (randX 10 bit, randY 9 bit) and turns it into a validated food position for the snake game.
- Samples a candidate, clamps it to the playfield, and rejects it if it is off-grid. It then asks the snake-body occupancy checker whether the cell is free.
- Holds the accepted food position until the snake eats it.
- Sits between the random point generator and the renderer/collision logic.

---
 rtl/snake_pkg.sv | 24 ++
 rtl/food_placer_point_qualifier.sv | 43 ++++
 rtl/food_placer.sv | 173 +++++++++++++++++
 tb/tb_food_placer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared coordinate types, placer state encoding and playfield
//               constants for the snake game.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

  typedef logic [9:0] xcoord_t;
  typedef logic [8:0] ycoord_t;

  typedef enum logic [1:0] {
    SAMPLE = 2'd0,
    CHECK  = 2'd1,
    HOLD   = 2'd2
  } fp_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int GRID     = 10;

endpackage
`default_nettype wire

// File: rtl/food_placer_point_qualifier.sv
`default_nettype none
// ============================================================================
// Module      : point_qualifier
// Description : Clamps a raw random point into the legal food window and
//               flags whether the clamped point sits on the cell grid.
// Revision    : 1.0 - initial release
// ============================================================================
module point_qualifier
  import snake_pkg::*;
#(
  parameter int GRID  = snake_pkg::GRID,
  parameter int X_MIN = 20,
  parameter int X_MAX = 620,
  parameter int Y_MIN = 20,
  parameter int Y_MAX = 460
) (
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  output logic [9:0] cx_o,
  output logic [8:0] cy_o,
  output logic       aligned_o
);

  localparam xcoord_t X_LO = xcoord_t'(X_MIN);
  localparam xcoord_t X_HI = xcoord_t'(X_MAX);
  localparam ycoord_t Y_LO = ycoord_t'(Y_MIN);
  localparam ycoord_t Y_HI = ycoord_t'(Y_MAX);
  localparam xcoord_t GX   = xcoord_t'(GRID);
  localparam ycoord_t GY   = ycoord_t'(GRID);

  // Unsigned inclusive clamp, then constant-modulus grid test on the result.
  always_comb begin
    cx_o = x_i;
    if (x_i < X_LO)      cx_o = X_LO;
    else if (x_i > X_HI) cx_o = X_HI;
    cy_o = y_i;
    if (y_i < Y_LO)      cy_o = Y_LO;
    else if (y_i > Y_HI) cy_o = Y_HI;
    aligned_o = ((cx_o % GX) == '0) && ((cy_o % GY) == '0);
  end

endmodule
`default_nettype wire

// File: rtl/food_placer.sv
`default_nettype none
// ============================================================================
// Module      : food_placer
// Description : Turns the free-running random point stream into a validated,
//               unoccupied food position and holds it until eaten.
// Revision    : 1.0 - initial release
// ============================================================================
module food_placer
  import snake_pkg::*;
#(
  parameter int GRID       = snake_pkg::GRID,
  parameter int X_MIN      = 20,
  parameter int X_MAX      = 620,
  parameter int Y_MIN      = 20,
  parameter int Y_MAX      = 460,
  parameter int MAX_TRIES  = 8,
  parameter int FALLBACK_X = 320,
  parameter int FALLBACK_Y = 240
) (
  input  logic       VGA_clk,
  input  logic       reset_n,
  input  logic [9:0] randX,
  input  logic [8:0] randY,
  input  logic       eat,
  output logic       chk_req,
  output logic [9:0] chk_x,
  output logic [8:0] chk_y,
  input  logic       chk_done,
  input  logic       chk_hit,
  output logic [9:0] food_x,
  output logic [8:0] food_y,
  output logic       food_valid,
  output logic       new_food,
  output logic [7:0] food_count
);

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRIES_W-1:0] TRIES_LIMIT = TRIES_W'(MAX_TRIES);

  fp_state_t          state_q, state_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic               chk_req_q, chk_req_d;
  xcoord_t            chk_x_q, chk_x_d;
  ycoord_t            chk_y_q, chk_y_d;
  xcoord_t            food_x_q, food_x_d;
  ycoord_t            food_y_q, food_y_d;
  logic               food_valid_q, food_valid_d;
  logic               new_food_q, new_food_d;
  logic [7:0]         food_count_q, food_count_d;

  xcoord_t            cx;
  ycoord_t            cy;
  logic               aligned;
  logic [TRIES_W-1:0] tries_inc;
  logic               fallback;

  point_qualifier #(
    .GRID  (GRID),
    .X_MIN (X_MIN),
    .X_MAX (X_MAX),
    .Y_MIN (Y_MIN),
    .Y_MAX (Y_MAX)
  ) u_qual (
    .x_i       (randX),
    .y_i       (randY),
    .cx_o      (cx),
    .cy_o      (cy),
    .aligned_o (aligned)
  );

  assign tries_inc = tries_q + 1'b1;

  // State register; async reset so a mid-query reset drops chk_req at once.
  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SAMPLE;
      tries_q      <= '0;
      chk_req_q    <= 1'b0;
      chk_x_q      <= '0;
      chk_y_q      <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      new_food_q   <= 1'b0;
      food_count_q <= '0;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      chk_req_q    <= chk_req_d;
      chk_x_q      <= chk_x_d;
      chk_y_q      <= chk_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      new_food_q   <= new_food_d;
      food_count_q <= food_count_d;
    end
  end

  // Next-state: sample/qualify, query occupancy, hold; rejections count
  // toward the try limit, which forces the fixed fallback cell.
  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    chk_req_d    = chk_req_q;
    chk_x_d      = chk_x_q;
    chk_y_d      = chk_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    new_food_d   = 1'b0;
    food_count_d = food_count_q;
    fallback     = 1'b0;

    case (state_q)
      SAMPLE: begin
        if (aligned) begin
          chk_x_d   = cx;
          chk_y_d   = cy;
          chk_req_d = 1'b1;
          state_d   = CHECK;
        end else begin
          tries_d  = tries_inc;
          fallback = (tries_inc == TRIES_LIMIT);
        end
      end
      CHECK: begin
        if (chk_done && chk_req_q) begin
          chk_req_d = 1'b0;
          if (!chk_hit) begin
            food_x_d     = chk_x_q;
            food_y_d     = chk_y_q;
            food_valid_d = 1'b1;
            new_food_d   = 1'b1;
            state_d      = HOLD;
          end else begin
            tries_d  = tries_inc;
            fallback = (tries_inc == TRIES_LIMIT);
            state_d  = SAMPLE;
          end
        end
      end
      HOLD: begin
        if (eat) begin
          food_valid_d = 1'b0;
          food_count_d = food_count_q + 8'd1;
          tries_d      = '0;
          state_d      = SAMPLE;
        end
      end
      default: state_d = SAMPLE;
    endcase

    if (fallback) begin
      food_x_d     = xcoord_t'(FALLBACK_X);
      food_y_d     = ycoord_t'(FALLBACK_Y);
      food_valid_d = 1'b1;
      new_food_d   = 1'b1;
      state_d      = HOLD;
    end
  end

  assign chk_req    = chk_req_q;
  assign chk_x      = chk_x_q;
  assign chk_y      = chk_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign new_food   = new_food_q;
  assign food_count = food_count_q;

endmodule
`default_nettype wire

// File: tb/tb_food_placer.sv
`default_nettype none
// ============================================================================
// Module      : tb_food_placer
// Description : Self-checking bench for food_placer with a scoreboard of
//               expected placements and a behavioural occupancy checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_food_placer;

  logic       VGA_clk = 1'b0;
  logic       reset_n;
  logic [9:0] randX;
  logic [8:0] randY;
  logic       eat;
  logic       chk_req;
  logic [9:0] chk_x;
  logic [8:0] chk_y;
  logic       chk_done;
  logic       chk_hit;
  logic [9:0] food_x;
  logic [8:0] food_y;
  logic       food_valid;
  logic       new_food;
  logic [7:0] food_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_count = 0;
  int resp_delay = 0;
  bit resp_hit = 1'b0;
  int n_req = 0;
  int wcnt = 0;
  logic [18:0] sb_q[$];
  logic [18:0] sb_e;

  food_placer dut (
    .VGA_clk    (VGA_clk),
    .reset_n    (reset_n),
    .randX      (randX),
    .randY      (randY),
    .eat        (eat),
    .chk_req    (chk_req),
    .chk_x      (chk_x),
    .chk_y      (chk_y),
    .chk_done   (chk_done),
    .chk_hit    (chk_hit),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .new_food   (new_food),
    .food_count (food_count)
  );

  always #5 VGA_clk = ~VGA_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Occupancy checker model: answers after resp_delay waiting cycles.
  always begin
    @(posedge VGA_clk);
    #2;
    chk_done = 1'b0;
    if (reset_n === 1'b1 && chk_req === 1'b1) begin
      if (wcnt >= resp_delay) begin
        chk_done = 1'b1;
        chk_hit  = resp_hit;
        wcnt     = 0;
        n_req++;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Scoreboard: every new_food pulse must match the oldest expected placement.
  always begin
    @(posedge VGA_clk);
    #1;
    if (reset_n === 1'b1 && new_food === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_food", 1, 0);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_food_x", food_x, sb_e[18:9]);
        check("sb_food_y", food_y, sb_e[8:0]);
        check("sb_food_valid", food_valid, 1);
      end
    end
  end

  function automatic logic [18:0] pt(input int x, input int y);
    return {10'(x), 9'(y)};
  endfunction

  task automatic do_eat();
    @(negedge VGA_clk);
    eat = 1'b1;
    @(posedge VGA_clk);
    #1;
    eat = 1'b0;
    exp_count = (exp_count + 1) % 256;
    check("eat_valid_drop", food_valid, 0);
    check("eat_count", food_count, exp_count);
  endtask

  task automatic wait_food(input int bound);
    int k = 0;
    while (food_valid !== 1'b1 && k < bound) begin
      @(posedge VGA_clk);
      #1;
      k++;
    end
    check("wait_food", food_valid, 1);
  endtask

  task automatic place_fast(input int xi, input int yi, input int xe, input int ye);
    randX = 10'(xi);
    randY = 9'(yi);
    sb_q.push_back(pt(xe, ye));
    do_eat();
    @(posedge VGA_clk);
    #1;
    check("pf_req", chk_req, 1);
    check("pf_chk_x", chk_x, xe);
    check("pf_chk_y", chk_y, ye);
    @(posedge VGA_clk);
    #1;
    check("pf_valid", food_valid, 1);
    check("pf_new", new_food, 1);
    check("pf_req_drop", chk_req, 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    eat      = 1'b0;
    chk_done = 1'b0;
    chk_hit  = 1'b0;
    randX    = 10'd300;
    randY    = 9'd200;
    repeat (3) @(posedge VGA_clk);
    #1;
    check("rst_chk_req", chk_req, 0);
    check("rst_chk_x", chk_x, 0);
    check("rst_chk_y", chk_y, 0);
    check("rst_food_x", food_x, 0);
    check("rst_food_y", food_y, 0);
    check("rst_food_valid", food_valid, 0);
    check("rst_new_food", new_food, 0);
    check("rst_food_count", food_count, 0);

    // First placement straight out of reset.
    sb_q.push_back(pt(300, 200));
    @(negedge VGA_clk);
    reset_n = 1'b1;
    @(posedge VGA_clk);
    #1;
    check("first_req", chk_req, 1);
    check("first_chk_x", chk_x, 300);
    check("first_chk_y", chk_y, 200);
    check("first_valid_low", food_valid, 0);
    @(posedge VGA_clk);
    #1;
    check("first_valid", food_valid, 1);
    check("first_new", new_food, 1);
    @(posedge VGA_clk);
    #1;
    check("first_new_pulse", new_food, 0);
    check("first_hold", food_x, 300);

    // Clamping, including inclusive bounds and saturated inputs.
    place_fast(630, 470, 620, 460);
    place_fast(5, 1, 20, 20);
    place_fast(620, 460, 620, 460);
    place_fast(1023, 511, 620, 460);
    place_fast(20, 20, 20, 20);

    // Off-grid candidates are retried without querying the checker.
    randX = 10'd123;
    randY = 9'd200;
    sb_q.push_back(pt(400, 200));
    do_eat();
    for (int i = 0; i < 3; i++) begin
      @(posedge VGA_clk);
      #1;
      check("offgrid_no_req", chk_req, 0);
    end
    randX = 10'd400;
    @(posedge VGA_clk);
    #1;
    check("offgrid_req", chk_req, 1);
    check("offgrid_chk_x", chk_x, 400);
    wait_food(10);

    // Every query reports occupied: fallback after MAX_TRIES requests.
    resp_hit = 1'b1;
    n_req = 0;
    randX = 10'd300;
    randY = 9'd200;
    sb_q.push_back(pt(320, 240));
    do_eat();
    wait_food(100);
    check("fb_new", new_food, 1);
    check("fb_requests", n_req, 8);
    check("fb_x", food_x, 320);
    check("fb_y", food_y, 240);
    resp_hit = 1'b0;

    // Slow checker: request held stable; eat during CHECK is ignored.
    resp_delay = 5;
    randX = 10'd500;
    randY = 9'd300;
    sb_q.push_back(pt(500, 300));
    do_eat();
    @(posedge VGA_clk);
    #1;
    check("slow_req", chk_req, 1);
    eat = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge VGA_clk);
      #1;
      eat = 1'b0;
      check("slow_req_held", chk_req, 1);
      check("slow_x_stable", chk_x, 500);
      check("slow_y_stable", chk_y, 300);
      check("slow_not_valid", food_valid, 0);
    end
    @(posedge VGA_clk);
    #1;
    check("slow_valid", food_valid, 1);
    check("slow_count_kept", food_count, exp_count);
    resp_delay = 0;

    // Eat count wraps 255 -> 0.
    for (int i = 0; i < 300 && exp_count != 0; i++) begin
      place_fast(300, 200, 300, 200);
    end
    check("count_wrap", food_count, 0);

    // Reset asserted while waiting on the checker.
    resp_delay = 5;
    do_eat();
    @(posedge VGA_clk);
    #1;
    check("mid_req", chk_req, 1);
    @(posedge VGA_clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", chk_req, 0);
    check("mid_rst_chk_x", chk_x, 0);
    check("mid_rst_food_x", food_x, 0);
    check("mid_rst_valid", food_valid, 0);
    check("mid_rst_count", food_count, 0);
    exp_count  = 0;
    resp_delay = 0;
    randX = 10'd100;
    randY = 9'd50;
    sb_q.push_back(pt(100, 50));
    @(negedge VGA_clk);
    reset_n = 1'b1;
    wait_food(20);
    check("post_rst_x", food_x, 100);
    check("post_rst_y", food_y, 50);
    repeat (2) @(posedge VGA_clk);
    #1;
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
